// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests over a
// req/ack handshake, and buffers one instruction (plus one skid entry) for decode.
// Redirects are deferred past the delay-slot fetch.
// Optional feature macro: EXC_EN adds the exc_valid port and the S_DRAIN state.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc8_out,
  output logic        addr_err
`ifdef EXC_EN
  ,
  input  logic        exc_valid
`endif
);

`ifdef EXC_EN
  typedef enum logic [1:0] {StReq, StFull, StDrain} state_e;
`else
  typedef enum logic [1:0] {StReq, StFull} state_e;
  logic [31:0] unused_exc_pc;
  assign unused_exc_pc = EXC_PC;
`endif

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc8_q, pc8_d;
  logic        err_q, err_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_err_q, skid_err_d;

  logic        consume, free;
  logic        complete, cpl_err;
  logic [31:0] cpl_instr;
  logic        pend_v_eff;
  logic [31:0] pend_pc_eff, next_pc;
  logic        do_issue;
  logic [31:0] issue_pc;

  // Next-state: handshake completion, buffer/skid movement, PC advance.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pc8_d        = pc8_q;
    err_d        = err_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_err_d   = skid_err_q;
    complete     = 1'b0;
    cpl_instr    = imem_rdata;
    cpl_err      = 1'b0;
    do_issue     = 1'b0;
    issue_pc     = fetch_pc_q;

    consume     = valid_q & ~stall;
    free        = ~valid_q | ~stall;
    // A redirect arriving on the completing edge takes effect immediately.
    pend_v_eff  = redirect_valid | pend_valid_q;
    pend_pc_eff = redirect_valid ? redirect_pc : pend_pc_q;
    next_pc     = pend_v_eff ? pend_pc_eff : fetch_pc_q + 32'd4;
    pend_valid_d = pend_v_eff;
    pend_pc_d    = pend_pc_eff;

    if (consume) valid_d = 1'b0;

    case (state_q)
      StReq: begin
        if (imem_req_q) begin
          complete = imem_ack;
        end else if (fetch_pc_q[1:0] != 2'b00) begin
          // Misaligned PC never reaches memory; deliver a nop flagged as an error.
          complete  = 1'b1;
          cpl_instr = 32'h0;
          cpl_err   = 1'b1;
        end else begin
          do_issue = 1'b1;
        end
      end
      StFull: begin
        if (consume) begin
          valid_d  = 1'b1;
          instr_d  = skid_instr_q;
          pc_d     = skid_pc_q;
          pc8_d    = skid_pc_q + 32'd8;
          err_d    = skid_err_q;
          state_d  = StReq;
          do_issue = 1'b1;
        end
      end
`ifdef EXC_EN
      StDrain: begin
        // Data returned for the abandoned request is dropped.
        if (imem_ack) begin
          state_d  = StReq;
          do_issue = 1'b1;
        end
      end
`endif
      default: state_d = StReq;
    endcase

    if (complete) begin
      fetch_pc_d   = next_pc;
      pend_valid_d = 1'b0;
      if (free) begin
        valid_d  = 1'b1;
        instr_d  = cpl_instr;
        pc_d     = fetch_pc_q;
        pc8_d    = fetch_pc_q + 32'd8;
        err_d    = cpl_err;
        do_issue = 1'b1;
        issue_pc = next_pc;
      end else begin
        skid_instr_d = cpl_instr;
        skid_pc_d    = fetch_pc_q;
        skid_err_d   = cpl_err;
        state_d      = StFull;
        imem_req_d   = 1'b0;
      end
    end

    // Misaligned targets leave req low; StReq then synthesises the entry.
    if (do_issue) begin
      imem_req_d = (issue_pc[1:0] == 2'b00);
      if (issue_pc[1:0] == 2'b00) imem_addr_d = issue_pc;
    end

`ifdef EXC_EN
    if (exc_valid) begin
      valid_d      = 1'b0;
      pend_valid_d = 1'b0;
      fetch_pc_d   = EXC_PC;
      if (imem_req_q && !imem_ack) begin
        state_d     = StDrain;
        imem_req_d  = 1'b1;
        imem_addr_d = imem_addr_q;
      end else begin
        state_d    = StReq;
        imem_req_d = (EXC_PC[1:0] == 2'b00);
        if (EXC_PC[1:0] == 2'b00) imem_addr_d = EXC_PC;
      end
    end
`endif
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReq;
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= 32'h0;
      pend_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      pc_q         <= 32'h0;
      pc8_q        <= 32'h0;
      err_q        <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc8_q        <= pc8_d;
      err_q        <= err_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_q;
  assign pc8_out     = pc8_q;
  assign addr_err    = err_q;

endmodule
